// File: rtl/muldiv_ctrl.sv
// muldiv_ctrl: multi-cycle MULT/MULTU/DIV/DIVU sequencer that owns the HI/LO registers.
// Build option MULDIV_DIV0_EARLY_EN: divide-by-zero bypasses the DIV iterations.
module muldiv_ctrl #(
  parameter int DATA_W    = 32,
  parameter int DIV_STEPS = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [2:0]        op,
  input  logic [DATA_W-1:0] busA,
  input  logic [DATA_W-1:0] busB,
  input  logic              flush,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] hi,
  output logic [DATA_W-1:0] lo
);

  localparam int HALF_W = DATA_W / 2;
  localparam int ITERS  = DATA_W / DIV_STEPS;
  localparam int CNT_W  = (ITERS > 4) ? $clog2(ITERS) : 2;

  localparam logic [2:0] OP_DIVU = 3'd3;
  localparam logic [2:0] OP_MTHI = 3'd4;
  localparam logic [2:0] OP_MTLO = 3'd5;

  typedef enum logic [1:0] {IDLE, MUL, DIV, FIX} state_t;

  state_t state, state_nxt;

  // Operand/sign capture and iteration state
  logic [CNT_W-1:0]    cnt;
  logic [DATA_W-1:0]   a_mag, b_mag, a_raw;
  logic                res_sign, rem_sign, is_div, div0, fix_hold;
  logic [2*DATA_W-1:0] acc;
  logic [DATA_W-1:0]   rem, quo;

  // Control strobes
  logic accept_md, early_div0, mt_hi_wr, mt_lo_wr, mul_step, div_step, fix_fire;

  // Datapath combinational values
  logic                sa, sb;
  logic [DATA_W-1:0]   a_abs, b_abs;
  logic [HALF_W-1:0]   pp_a, pp_b;
  logic [DATA_W-1:0]   pp;
  logic [2*DATA_W-1:0] pp_ext;
  logic [DATA_W:0]     shifted, trial;
  logic [DATA_W-1:0]   rem_nxt, quo_nxt;
  logic [2*DATA_W-1:0] prod_f;
  logic [DATA_W-1:0]   quo_f, rem_f, hi_fix, lo_fix;

  // Signed ops take two's-complement magnitudes; op[0] marks the unsigned variants.
  assign sa    = busA[DATA_W-1] & ~op[0];
  assign sb    = busB[DATA_W-1] & ~op[0];
  assign a_abs = sa ? -busA : busA;
  assign b_abs = sb ? -busB : busB;

`ifdef MULDIV_DIV0_EARLY_EN
  assign early_div0 = op[1] && (busB == '0);
`else
  assign early_div0 = 1'b0;
`endif

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  // NOTE: sequential state is updated with non-blocking assignments only, so every
  // register samples the pre-edge values regardless of block ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // ---------------------------------------------------------------------------
  // FSM: next-state logic
  // ---------------------------------------------------------------------------
  // NOTE: each always_comb assigns a default to every output first, so no latch is inferred.
  always_comb begin
    state_nxt = state;
    if (flush) begin
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE: if (accept_md) state_nxt = early_div0 ? FIX : (op[1] ? DIV : MUL);
        MUL:  if (cnt == CNT_W'(3)) state_nxt = FIX;
        DIV:  if (cnt == CNT_W'(ITERS - 1)) state_nxt = FIX;
        FIX:  if (!fix_hold) state_nxt = IDLE;
        default: state_nxt = IDLE;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: output / strobe logic
  // ---------------------------------------------------------------------------
  always_comb begin
    busy      = (state != IDLE);
    accept_md = 1'b0;
    mt_hi_wr  = 1'b0;
    mt_lo_wr  = 1'b0;
    mul_step  = 1'b0;
    div_step  = 1'b0;
    fix_fire  = 1'b0;
    if (!flush) begin
      case (state)
        IDLE: begin
          accept_md = start && (op <= OP_DIVU);
          mt_hi_wr  = start && (op == OP_MTHI);
          mt_lo_wr  = start && (op == OP_MTLO);
        end
        MUL:     mul_step = 1'b1;
        DIV:     div_step = 1'b1;
        FIX:     fix_fire = !fix_hold;
        default: ;
      endcase
    end
  end

  // 16x16 partial product, cnt selects {lo*lo, lo*hi, hi*lo, hi*hi}
  always_comb begin
    pp_a = cnt[1] ? a_mag[DATA_W-1:HALF_W] : a_mag[HALF_W-1:0];
    pp_b = cnt[0] ? b_mag[DATA_W-1:HALF_W] : b_mag[HALF_W-1:0];
    pp   = DATA_W'(pp_a) * DATA_W'(pp_b);
    case (cnt[1:0])
      2'd0:       pp_ext = {{DATA_W{1'b0}}, pp};
      2'd1, 2'd2: pp_ext = {{HALF_W{1'b0}}, pp, {HALF_W{1'b0}}};
      default:    pp_ext = {pp, {DATA_W{1'b0}}};
    endcase
  end

  // Restoring divider: dividend shifts out of quo MSB-first, quotient bits shift in.
  always_comb begin
    rem_nxt = rem;
    quo_nxt = quo;
    shifted = '0;
    trial   = '0;
    for (int s = 0; s < DIV_STEPS; s++) begin
      shifted = {rem_nxt, quo_nxt[DATA_W-1]};
      trial   = shifted - {1'b0, b_mag};
      quo_nxt = {quo_nxt[DATA_W-2:0], ~trial[DATA_W]};
      rem_nxt = trial[DATA_W] ? shifted[DATA_W-1:0] : trial[DATA_W-1:0];
    end
  end

  // Sign fix-up and HI/LO selection for the FIX edge
  always_comb begin
    prod_f = res_sign ? -acc : acc;
    quo_f  = res_sign ? -quo : quo;
    rem_f  = rem_sign ? -rem : rem;
    if (!is_div) begin
      hi_fix = prod_f[2*DATA_W-1:DATA_W];
      lo_fix = prod_f[DATA_W-1:0];
    end else if (div0) begin
      hi_fix = a_raw;
      lo_fix = '1;
    end else begin
      hi_fix = rem_f;
      lo_fix = quo_f;
    end
  end

  // ---------------------------------------------------------------------------
  // Datapath registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt      <= '0;
      a_mag    <= '0;
      b_mag    <= '0;
      a_raw    <= '0;
      res_sign <= 1'b0;
      rem_sign <= 1'b0;
      is_div   <= 1'b0;
      div0     <= 1'b0;
      fix_hold <= 1'b0;
      acc      <= '0;
      rem      <= '0;
      quo      <= '0;
      done     <= 1'b0;
      hi       <= '0;
      lo       <= '0;
    end else begin
      done <= fix_fire;
      if (accept_md) begin
        a_mag    <= a_abs;
        b_mag    <= b_abs;
        a_raw    <= busA;
        res_sign <= sa ^ sb;
        rem_sign <= sa;
        is_div   <= op[1];
        div0     <= (busB == '0);
        fix_hold <= early_div0;
        cnt      <= '0;
        acc      <= '0;
        rem      <= '0;
        quo      <= a_abs;
      end
      if (mul_step) begin
        acc <= acc + pp_ext;
        cnt <= cnt + CNT_W'(1);
      end
      if (div_step) begin
        rem <= rem_nxt;
        quo <= quo_nxt;
        cnt <= cnt + CNT_W'(1);
      end
      // The early divide-by-zero path spends one extra cycle in FIX to match its latency.
      if (state == FIX) fix_hold <= 1'b0;
      if (fix_fire) begin
        hi <= hi_fix;
        lo <= lo_fix;
      end
      if (mt_hi_wr) hi <= busA;
      if (mt_lo_wr) lo <= busA;
    end
  end

endmodule
